// File: rtl/led_pattern_gen.sv
// LED pattern engine: prescaled step tick driving rotate-left/right, bounce and fill patterns.
// A mode change reseeds the pattern, and any illegal pattern is reseeded on the next step.
module led_pattern_gen #(
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned TOPVALUE = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  output logic [WIDTH-1:0] qLeds,
  output logic             tick
);

  localparam int unsigned CW = $clog2(TOPVALUE + 1);

  localparam logic [1:0] ROT_L  = 2'b00;
  localparam logic [1:0] ROT_R  = 2'b01;
  localparam logic [1:0] BOUNCE = 2'b10;
  localparam logic [1:0] FILL   = 2'b11;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } dir_t;

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [CW-1:0]    limit_c;
  logic [WIDTH-1:0] leds_nxt;
  logic             tick_nxt;
  logic             term_c;
  logic             legal_c;
  logic [1:0]       mode_q;
  dir_t             dir;
  dir_t             dir_nxt;

  function automatic logic [WIDTH-1:0] seed(input logic [1:0] m);
    return (m == FILL) ? '0 : WIDTH'(1);
  endfunction

  // Speed divides the base period; a zero result clamps to one cycle per step.
  always_comb begin
    limit_c = CW'(TOPVALUE >> speed);
    if (limit_c == '0) limit_c = CW'(1);
  end

  assign term_c  = en && (cnt >= (limit_c - CW'(1)));
  assign legal_c = (mode_q == FILL) ? ((qLeds & (qLeds + WIDTH'(1))) == '0)
                                    : $onehot(qLeds);

  always_comb begin
    cnt_nxt  = cnt;
    leds_nxt = qLeds;
    dir_nxt  = dir;
    tick_nxt = 1'b0;
    if (mode != mode_q) begin
      cnt_nxt  = '0;
      leds_nxt = seed(mode);
      dir_nxt  = LEFT;
    end else if (term_c) begin
      cnt_nxt  = '0;
      tick_nxt = 1'b1;
      if (!legal_c) begin
        leds_nxt = seed(mode_q);
        dir_nxt  = LEFT;
      end else begin
        case (mode_q)
          ROT_L: leds_nxt = (qLeds << 1) | (qLeds >> (WIDTH - 1));
          ROT_R: leds_nxt = (qLeds >> 1) | (qLeds << (WIDTH - 1));
          BOUNCE: begin
            // A single LED has nowhere to move, so it simply holds.
            if (WIDTH > 1) begin
              if (dir == LEFT) begin
                if (qLeds[WIDTH-1]) begin
                  dir_nxt  = RIGHT;
                  leds_nxt = qLeds >> 1;
                end else begin
                  leds_nxt = qLeds << 1;
                end
              end else begin
                if (qLeds[0]) begin
                  dir_nxt  = LEFT;
                  leds_nxt = qLeds << 1;
                end else begin
                  leds_nxt = qLeds >> 1;
                end
              end
            end
          end
          default: leds_nxt = (&qLeds) ? '0 : ((qLeds << 1) | WIDTH'(1));
        endcase
      end
    end else if (en) begin
      cnt_nxt = cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      tick   <= 1'b0;
      dir    <= LEFT;
      mode_q <= mode;
      qLeds  <= seed(mode);
    end else begin
      cnt    <= cnt_nxt;
      tick   <= tick_nxt;
      dir    <= dir_nxt;
      mode_q <= mode;
      qLeds  <= leds_nxt;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed scenarios pinned with literal values, then random
// stimulus, all checked every cycle against a step-count model of the patterns.
module tb_led_pattern_gen;

  localparam int unsigned W   = 10;
  localparam int unsigned TOP = 4;

  logic         clk;
  logic         rst;
  logic         en;
  logic [1:0]   mode;
  logic [1:0]   speed;
  logic [W-1:0] qLeds;
  logic         tick;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: steps taken since the last seed, and prescaler position.
  int   m_phase  = 0;
  int   m_cnt    = 0;
  logic m_tick   = 1'b0;
  logic [1:0] m_mode = 2'b00;

  led_pattern_gen #(.WIDTH(W), .TOPVALUE(TOP)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .mode  (mode),
    .speed (speed),
    .qLeds (qLeds),
    .tick  (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] exp_leds(input logic [1:0] md, input int ph);
    logic [W-1:0] one;
    int per;
    int x;
    int p;
    one = W'(1);
    case (md)
      2'b00: p = ph % W;
      2'b01: p = (W - (ph % W)) % W;
      2'b10: begin
        per = 2 * (W - 1);
        x   = ph % per;
        p   = (x <= W - 1) ? x : per - x;
      end
      default: return (one << (ph % (W + 1))) - one;
    endcase
    return one << p;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each edge, then compare the registered outputs just after it.
  always @(posedge clk) begin
    int lim;
    if (rst) begin
      m_cnt = 0; m_tick = 1'b0; m_phase = 0; m_mode = mode;
    end else if (mode != m_mode) begin
      m_cnt = 0; m_tick = 1'b0; m_phase = 0; m_mode = mode;
    end else if (en) begin
      lim = TOP >> speed;
      if (lim < 1) lim = 1;
      if (m_cnt >= lim - 1) begin
        m_cnt = 0; m_tick = 1'b1; m_phase++;
      end else begin
        m_cnt++; m_tick = 1'b0;
      end
    end else begin
      m_tick = 1'b0;
    end
    #1;
    check("model_leds", 32'(qLeds), 32'(exp_leds(m_mode, m_phase)));
    check("model_tick", 32'(tick), 32'(m_tick));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; mode = 2'b00; speed = 2'b00;

    // Reset, then rotate left with a tick every 4 clocks and a wrap at tick 10.
    cyc(3);
    check("rst_leds", 32'(qLeds), 32'h001);
    check("rst_tick", 32'(tick), 32'h0);
    rst = 1'b0;
    cyc(3);
    check("pre_tick", 32'(tick), 32'h0);
    cyc(1);
    check("rotl_t1_leds", 32'(qLeds), 32'h002);
    check("rotl_t1_tick", 32'(tick), 32'h1);
    cyc(36);
    check("rotl_wrap_leds", 32'(qLeds), 32'h001);
    check("rotl_wrap_tick", 32'(tick), 32'h1);

    // Rotate right and fill seeds.
    rst = 1'b1; mode = 2'b01;
    cyc(1);
    rst = 1'b0;
    cyc(4);
    check("rotr_t1", 32'(qLeds), 32'h200);
    cyc(4);
    check("rotr_t2", 32'(qLeds), 32'h100);
    rst = 1'b1; mode = 2'b11;
    cyc(1);
    check("fill_seed", 32'(qLeds), 32'h000);

    // Mode change 00 -> 11 in the middle of a count.
    mode = 2'b00;
    cyc(1);
    rst = 1'b0;
    cyc(2);
    mode = 2'b11;
    cyc(1);
    check("chg_leds", 32'(qLeds), 32'h000);
    check("chg_tick", 32'(tick), 32'h0);
    cyc(4);
    check("fill_t1", 32'(qLeds), 32'h001);
    cyc(4);
    check("fill_t2", 32'(qLeds), 32'h003);

    // Pause at cnt=2, resume, then faster speeds.
    cyc(2);
    en = 1'b0;
    cyc(7);
    check("pause_leds", 32'(qLeds), 32'h003);
    check("pause_tick", 32'(tick), 32'h0);
    en = 1'b1;
    cyc(1);
    check("resume_tick0", 32'(tick), 32'h0);
    cyc(1);
    check("resume_leds", 32'(qLeds), 32'h007);
    check("resume_tick1", 32'(tick), 32'h1);
    speed = 2'd1;
    cyc(1);
    check("spd1_gap", 32'(tick), 32'h0);
    cyc(1);
    check("spd1_leds", 32'(qLeds), 32'h00F);
    speed = 2'd3;
    cyc(1);
    check("spd3_a", 32'(qLeds), 32'h01F);
    cyc(1);
    check("spd3_b", 32'(qLeds), 32'h03F);
    check("spd3_tick", 32'(tick), 32'h1);

    // Bounce, then reset while the prescaler is terminal.
    mode = 2'b10; speed = 2'd0;
    cyc(1);
    check("bnc_seed", 32'(qLeds), 32'h001);
    cyc(12);
    check("bnc_t3", 32'(qLeds), 32'h008);
    cyc(3);
    rst = 1'b1;
    cyc(1);
    check("rst_term_leds", 32'(qLeds), 32'h001);
    check("rst_term_tick", 32'(tick), 32'h0);
    rst = 1'b0;
    cyc(3);
    check("post_rst_gap", 32'(tick), 32'h0);
    cyc(1);
    check("post_rst_leds", 32'(qLeds), 32'h002);
    // A full bounce period past the first tick lands on the same position.
    cyc(4 * 18);
    check("bnc_period", 32'(qLeds), 32'h002);

    // Random traffic; the per-cycle model comparison does the checking.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 119) == 0) mode = 2'($urandom);
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 59) == 0) speed = 2'($urandom);
    end
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
